// File: rtl/freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of clk_in cycles and publishes the count with a one-cycle valid.
module freq_meter #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned GATE_CYCLES = CLK_FREQ,
  parameter int unsigned COUNT_W     = 27,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               sig_in,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic [COUNT_W-1:0] freq_out,
  output logic               freq_valid,
  output logic               overflow
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    GATE    = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 prev_q;
  logic                 rise_c;
  logic [GATE_W-1:0]    gate_cnt;
  logic [COUNT_W-1:0]   edge_cnt;
  logic                 ovf_q;
  logic [COUNT_W-1:0]   cnt_nxt_c;
  logic                 ovf_nxt_c;

  // Synchronizer chain and edge detector; free-running in every state.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_c = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Saturating edge count; a rise while saturated marks the window as overflowed.
  always_comb begin
    cnt_nxt_c = edge_cnt;
    ovf_nxt_c = ovf_q;
    if (rise_c) begin
      if (edge_cnt == CNT_MAX) begin
        ovf_nxt_c = 1'b1;
      end else begin
        cnt_nxt_c = edge_cnt + COUNT_W'(1);
      end
    end
  end

  // Result registers load on entry to PUBLISH so they are visible during it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          edge_cnt <= '0;
          ovf_q    <= 1'b0;
          gate_cnt <= '0;
          state    <= GATE;
        end
        GATE: begin
          edge_cnt <= cnt_nxt_c;
          ovf_q    <= ovf_nxt_c;
          gate_cnt <= gate_cnt + GATE_W'(1);
          if (gate_cnt == GATE_LAST) begin
            state      <= PUBLISH;
            freq_out   <= cnt_nxt_c;
            overflow   <= ovf_nxt_c;
            freq_valid <= 1'b1;
          end
        end
        PUBLISH: begin
          if (continuous) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: 8-bit and 4-bit instances share stimulus and
// are checked against a window-counting reference model.
module tb_freq_meter;

  localparam int unsigned G = 100;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst, sig_in, start, continuous;
  logic       busy8, fv8, ov8;
  logic [7:0] fo8;
  logic       busy4, fv4, ov4;
  logic [3:0] fo4;

  freq_meter #(.CLK_FREQ(50_000_000), .GATE_CYCLES(G), .COUNT_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy8), .freq_out(fo8), .freq_valid(fv8), .overflow(ov8));

  freq_meter #(.CLK_FREQ(50_000_000), .GATE_CYCLES(G), .COUNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .busy(busy4), .freq_out(fo4), .freq_valid(fv4), .overflow(ov4));

  typedef struct {
    int due;
    int cnt;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: a window of G input samples starting at the accepting edge.
  bit m_active = 1'b0;
  bit m_prev   = 1'b0;
  int m_n0     = 0;
  int m_cnt    = 0;

  always @(posedge clk_in) begin
    int c;
    exp_t e;
    c = cyc;
    if (rst) begin
      m_active = 1'b0;
      m_prev   = 1'b0;
    end else begin
      if (m_active && c == m_n0 + G + 2) begin
        if (continuous) begin
          m_n0  = c;
          m_cnt = 0;
        end else begin
          m_active = 1'b0;
        end
      end else if (!m_active && start) begin
        m_active = 1'b1;
        m_n0     = c;
        m_cnt    = 0;
      end
      if (m_active && c >= m_n0 && c <= m_n0 + G - 1 && sig_in && !m_prev) m_cnt++;
      if (m_active && c == m_n0 + G + 1) begin
        e.due = c + 1;
        e.cnt = m_cnt;
        q8.push_back(e);
        q4.push_back(e);
      end
      m_prev = sig_in;
    end
    cyc = cyc + 1;
  end

  task automatic check_result(input string nm, input int due, input int cnt, input int maxv,
                              input int fo, input bit ov);
    int efo;
    bit eov;
    efo = (cnt > maxv) ? maxv : cnt;
    eov = (cnt > maxv);
    n_cmp++;
    if (cyc != due) begin
      n_fail++;
      $display("FAIL %s_time: freq_valid at cycle %0d, required %0d", nm, cyc, due);
    end
    n_cmp++;
    if (fo != efo) begin
      n_fail++;
      $display("FAIL %s_freq: freq_out=%0d, required %0d (cycle %0d)", nm, fo, efo, cyc);
    end
    n_cmp++;
    if (ov != eov) begin
      n_fail++;
      $display("FAIL %s_ovf: overflow=%0d, required %0d (cycle %0d)", nm, ov, eov, cyc);
    end
  endtask

  task automatic expect_eq(input string nm, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, got, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each freq_valid and tracks busy every cycle.
  always @(negedge clk_in) begin
    exp_t e;
    if (fv8 === 1'b1) begin
      if (q8.size() == 0) begin
        expect_eq("unexpected_valid8", 1, 0);
      end else begin
        e = q8.pop_front();
        check_result("w8", e.due, e.cnt, 255, int'(fo8), ov8);
      end
    end else if (q8.size() > 0 && cyc > q8[0].due) begin
      e = q8.pop_front();
      expect_eq("missing_valid8", 0, 1);
    end
    if (fv4 === 1'b1) begin
      if (q4.size() == 0) begin
        expect_eq("unexpected_valid4", 1, 0);
      end else begin
        e = q4.pop_front();
        check_result("w4", e.due, e.cnt, 15, int'(fo4), ov4);
      end
    end else if (q4.size() > 0 && cyc > q4[0].due) begin
      e = q4.pop_front();
      expect_eq("missing_valid4", 0, 1);
    end
    expect_eq("busy8", int'(busy8), int'(m_active));
    expect_eq("busy4", int'(busy4), int'(m_active));
  end

  // Background signal generator: 0 = driven by main, 1 = square wave, 2 = random.
  int sig_mode = 0;
  int half     = 5;
  int ph       = 0;

  initial begin
    forever begin
      @(negedge clk_in);
      if (sig_mode == 1) begin
        ph++;
        if (ph >= half) begin
          ph     = 0;
          sig_in = ~sig_in;
        end
      end else if (sig_mode == 2) begin
        sig_in = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_active && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    if (t >= 2000) expect_eq("wait_idle_timeout", t, 0);
    tick(3);
  endtask

  initial begin
    rst        = 1'b1;
    sig_in     = 1'b0;
    start      = 1'b0;
    continuous = 1'b0;

    // Reset state
    tick(2);
    rst = 1'b0;
    tick(1);
    expect_eq("rst_busy", int'(busy8), 0);
    expect_eq("rst_freq", int'(fo8), 0);
    expect_eq("rst_valid", int'(fv8), 0);
    expect_eq("rst_ovf", int'(ov8), 0);
    expect_eq("rst_freq4", int'(fo4), 0);
    expect_eq("rst_ovf4", int'(ov4), 0);

    // Period 10 single shot
    sig_mode = 1;
    half     = 5;
    pulse_start();
    wait_idle();
    expect_eq("p10_freq", int'(fo8), 10);
    expect_eq("p10_ovf", int'(ov8), 0);
    expect_eq("p10_idle", int'(busy8), 0);

    // Constant high gives zero, then one edge on the last gate sample
    sig_mode = 0;
    sig_in   = 1'b1;
    tick(5);
    pulse_start();
    wait_idle();
    expect_eq("hold_freq", int'(fo8), 0);
    expect_eq("hold_ovf", int'(ov8), 0);
    sig_in = 1'b0;
    tick(5);
    pulse_start();
    tick(G - 2);
    sig_in = 1'b1;
    wait_idle();
    expect_eq("last_edge_freq", int'(fo8), 1);
    sig_in = 1'b0;

    // Saturation on the narrow counter, then recovery
    sig_mode = 1;
    half     = 2;
    pulse_start();
    wait_idle();
    expect_eq("sat_freq4", int'(fo4), 15);
    expect_eq("sat_ovf4", int'(ov4), 1);
    expect_eq("sat_freq8", int'(fo8), 25);
    half = 5;
    pulse_start();
    wait_idle();
    expect_eq("recover_freq4", int'(fo4), 10);
    expect_eq("recover_ovf4", int'(ov4), 0);

    // start while busy is ignored
    pulse_start();
    tick(40);
    pulse_start();
    wait_idle();

    // Reset mid-gate discards the measurement
    pulse_start();
    tick(51);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_eq("midrst_busy", int'(busy8), 0);
    expect_eq("midrst_freq", int'(fo8), 0);
    expect_eq("midrst_ovf4", int'(ov4), 0);
    tick(G + 10);

    // Continuous mode, then drop continuous
    half       = 10;
    continuous = 1'b1;
    pulse_start();
    tick(3 * (G + 2));
    continuous = 1'b0;
    wait_idle();
    expect_eq("cont_freq", int'(fo8), 5);
    expect_eq("cont_idle", int'(busy8), 0);

    // Randomized runs
    for (int i = 0; i < 8; i++) begin
      if (i[0]) begin
        sig_mode = 2;
      end else begin
        sig_mode = 1;
        half     = int'($urandom_range(1, 8));
      end
      continuous = 1'($urandom_range(0, 1));
      pulse_start();
      for (int j = 0; j < 4; j++) begin
        tick(int'($urandom_range(20, 90)));
        if ($urandom_range(0, 1) == 1) pulse_start();
      end
      continuous = 1'b0;
      wait_idle();
      tick(int'($urandom_range(0, 5)));
    end

    tick(5);
    expect_eq("pending_results8", q8.size(), 0);
    expect_eq("pending_results4", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
